// File: rtl/serial_parallel_rx.sv
// Serial lane receiver: hunts for the idle comma to find byte alignment, then
// delivers MSB-first bytes with a valid qualifier once enough commas have been seen.
module serial_parallel_rx #(
   parameter logic [7:0]  COMMA      = 8'hBC,
   parameter int unsigned LOCK_COUNT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       data_in_serial,
   output logic [7:0] data_out_8b,
   output logic       valid_out,
   output logic       byte_stb,
   output logic       active
);

   typedef enum logic [1:0] {SEARCH, LOCKING, ACTIVE} state_t;

   localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

   state_t     state_q, state_d;
   logic [7:0] sr_q, sr_d;
   logic [7:0] data_q, data_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [3:0] bc_cnt_q, bc_cnt_d;
   logic       valid_q, valid_d;
   logic       stb_q, stb_d;

   logic [7:0] cand;
   logic       is_comma;
   logic       boundary;
   logic [3:0] bc_inc;

   assign cand     = {sr_q[6:0], data_in_serial};
   assign is_comma = (cand == COMMA);
   assign boundary = (bit_cnt_q == 3'd7);
   assign bc_inc   = bc_cnt_q + 4'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= SEARCH;
         sr_q      <= '0;
         data_q    <= '0;
         bit_cnt_q <= '0;
         bc_cnt_q  <= '0;
         valid_q   <= 1'b0;
         stb_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         data_q    <= data_d;
         bit_cnt_q <= bit_cnt_d;
         bc_cnt_q  <= bc_cnt_d;
         valid_q   <= valid_d;
         stb_q     <= stb_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sr_d      = cand;
      data_d    = data_q;
      bit_cnt_d = bit_cnt_q + 3'd1;
      bc_cnt_d  = bc_cnt_q;
      valid_d   = valid_q;
      stb_d     = 1'b0;
      unique case (state_q)
         SEARCH: begin
            // Phase is undefined until a comma is seen; the counter is held at
            // zero so the bit after a matching comma is bit 7 of the next byte.
            bit_cnt_d = '0;
            if (is_comma) begin
               bc_cnt_d = 4'd1;
               state_d  = (LOCK_N == 4'd1) ? ACTIVE : LOCKING;
            end
         end
         LOCKING: begin
            if (boundary) begin
               stb_d = 1'b1;
               if (is_comma) begin
                  if (bc_cnt_q != 4'hF) bc_cnt_d = bc_inc;
                  if (bc_inc == LOCK_N) state_d = ACTIVE;
               end else begin
                  state_d   = SEARCH;
                  bc_cnt_d  = '0;
                  bit_cnt_d = '0;
               end
            end
         end
         ACTIVE: begin
            if (boundary) begin
               stb_d = 1'b1;
               if (is_comma) begin
                  valid_d = 1'b0;
               end else begin
                  data_d  = cand;
                  valid_d = 1'b1;
               end
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   assign data_out_8b = data_q;
   assign valid_out   = valid_q;
   assign byte_stb    = stb_q;
   assign active      = (state_q == ACTIVE);

endmodule

// File: doc/serial_parallel_rx.md
Name: serial_parallel_rx

Overview:
- Receive-side counterpart of the transmit serializer for one PHY lane.
- Takes one MSB-first serial lane on the bit clock and finds byte alignment by hunting for the idle comma (COMMA, 0xBC), which the transmitter sends whenever its valid input is low.
- After LOCK_COUNT consecutive aligned commas it declares the lane active and delivers 8-bit bytes with a valid qualifier to the downstream 8-to-32 converter.
- One instance is used per lane (lane 0 and lane 1) in the PHY receiver.

Parameters:
- COMMA, 8'hBC, idle/alignment symbol sent by the transmitter when no valid data is present.
- LOCK_COUNT, 4, number of consecutive aligned commas needed to enter ACTIVE (legal range 1..15).

Ports:
- clk  input  1  bit clock; every rising edge samples one serial bit.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- data_in_serial  input  1  serial lane, MSB of each byte first.
- data_out_8b  output  8  last received non-comma byte while ACTIVE.
- valid_out  output  1  high while data_out_8b holds a data byte from the current byte slot.
- byte_stb  output  1  one-cycle pulse at each byte boundary once aligned (LOCKING or ACTIVE).
- active  output  1  high in ACTIVE state.

Behaviour:
- Reset values (asynchronous, reset high):
  - data_out_8b = 8'h00; valid_out, byte_stb, active = 0.
  - State = SEARCH; shift register = 0; bit_cnt = 0; bc_cnt = 0.
- Shift register sr[7:0]: each clk edge, sr <= {sr[6:0], data_in_serial}.
  - Candidate byte: cand = {sr[6:0], data_in_serial}, i.e. the byte completed by the bit sampled on this edge.
- SEARCH:
  - Every edge: if cand == COMMA, then bit_cnt <= 0 (the next bit is bit 7 of a new byte) and bc_cnt <= 1.
    - If LOCK_COUNT == 1, go to ACTIVE; otherwise go to LOCKING.
  - Outputs stay 0 in SEARCH; no byte_stb.
- Aligned states (LOCKING, ACTIVE):
  - bit_cnt increments 0..7 and wraps.
  - A byte boundary is the edge on which bit_cnt == 7; cand is evaluated only at boundaries.
  - byte_stb = 1 for exactly the cycle after each boundary edge (registered).
- LOCKING, at each boundary:
  - cand == COMMA: bc_cnt++. If the new bc_cnt == LOCK_COUNT, go to ACTIVE and set active = 1 on the same edge.
  - cand != COMMA: go to SEARCH, bc_cnt <= 0, bit_cnt <= 0.
    - The non-comma byte is discarded; valid_out stays 0.
- ACTIVE, at each boundary:
  - cand != COMMA: data_out_8b <= cand, valid_out <= 1.
  - cand == COMMA: valid_out <= 0; data_out_8b holds its previous value.
  - valid_out and data_out_8b are stable for the full 8-cycle byte slot between boundaries.
  - ACTIVE persists until reset. There is no loss-of-sync detection.
- Latency: the last bit of byte N is sampled at edge E. data_out_8b, valid_out and active reflect byte N after edge E; byte_stb is high in the cycle after edge E.
- Boundary conditions:
  - Comma across a byte boundary in SEARCH (bit-shifted pattern): locks at the first bit position where cand matches. Later misaligned bytes fail in LOCKING and return to SEARCH.
  - bc_cnt saturates; it is not used in ACTIVE.
  - bit_cnt wrap 7 -> 0 is unconditional in aligned states.
  - Reset asserted mid-byte: everything clears asynchronously. After deassertion the block hunts from SEARCH, and the partial byte is lost.
  - Reset deasserted coincident with a clk edge: that edge is ignored (first sample is on the next edge).

Test Plan:
- Reset check: assert reset with random serial input -> all outputs 0, active = 0; deassert and drive all-zero bits for 64 cycles -> outputs remain 0.
- Lock: 5 aligned 0xBC bytes -> active rises at the boundary of the 4th comma (edge 32 after the first comma bit); valid_out = 0; byte_stb pulses every 8 cycles from the first comma lock.
- Data: after lock, send 0xFF, 0x00, 0xA5, 0xBC, 0x3C -> data_out_8b/valid_out sequence is FF/1, 00/1, A5/1, A5/0, 3C/1, each stable for 8 cycles.
- Offset: 3 garbage bits then 4 commas -> lock at correct phase, active = 1. Separately, 2 commas then 0x12 -> return to SEARCH, active = 0; 4 more commas -> active = 1.
- Reset mid-byte: in ACTIVE, assert reset at bit 4 of byte 0x5A -> immediate clear; the re-lock sequence must work again.
- LOCK_COUNT = 1 build: a single comma -> active = 1 at that comma's boundary; the next byte 0x77 is delivered with valid_out = 1.
